nios_upc_pio_out_pulse: RTL and testbench

//  Avalon-MM output PIO (write side of the PIO pair) for the nios_upc system.

---
 rtl/nios_upc_pio_out_pulse_if.sv | 25 ++
 rtl/nios_upc_pio_out_pulse.sv | 165 ++++++++++++++++
 tb/tb_nios_upc_pio_out_pulse.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/nios_upc_pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for the nios_upc output PIO: select, address,
// write strobe, write data and registered read data.
interface nios_upc_pio_out_pulse_if;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect,
        output address,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_upc_pio_out_pulse.sv
// Output PIO with atomic set/clear and an optional one-shot pulse engine.
// The pulse engine (PW/PULSE/CNT registers) is present only when PIO_OUT_PULSE_EN is defined.
module nios_upc_pio_out_pulse #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}},
    parameter int                    PW_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    nios_upc_pio_out_pulse_if.slave    bus,
    output logic [DATA_WIDTH-1:0]      out_port
);

    logic                  wr_s;
    logic [DATA_WIDTH-1:0] wd_s;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] data_nx_s;
    logic [31:0]           readdata_r;
    logic [31:0]           rd_nx_s;
    logic                  unused_wd_s;

    assign wr_s        = bus.chipselect & ~bus.write_n;
    assign wd_s        = bus.writedata[DATA_WIDTH-1:0];
    assign unused_wd_s = ^bus.writedata;
    assign out_port    = data_r;
    assign bus.readdata = readdata_r;

`ifdef PIO_OUT_PULSE_EN
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic [PW_WIDTH-1:0]   pw_r;
    logic [PW_WIDTH-1:0]   pw_nx_s;
    logic [PW_WIDTH-1:0]   pw_eff_s;
    logic [PW_WIDTH-1:0]   cnt_r;
    logic [PW_WIDTH-1:0]   cnt_nx_s;
    logic [DATA_WIDTH-1:0] mask_r;
    logic [DATA_WIDTH-1:0] mask_nx_s;
    logic                  pulse_wr_s;

    // A stored width of zero behaves as a one-cycle pulse
    assign pw_eff_s   = (pw_r == {PW_WIDTH{1'b0}}) ? {{(PW_WIDTH-1){1'b0}}, 1'b1} : pw_r;
    assign pulse_wr_s = wr_s && (bus.address == 3'd4) && (wd_s != {DATA_WIDTH{1'b0}});

    // Bus write decode first, then pulse FSM; expiry clear overrides any bus set
    always_comb begin
        data_nx_s  = data_r;
        pw_nx_s    = pw_r;
        mask_nx_s  = mask_r;
        cnt_nx_s   = cnt_r;
        state_nx_s = state_r;
        if (wr_s) begin
            case (bus.address)
                3'd0:    data_nx_s = wd_s;
                3'd1:    pw_nx_s   = bus.writedata[PW_WIDTH-1:0];
                3'd2:    data_nx_s = data_r | wd_s;
                3'd3:    data_nx_s = data_r & ~wd_s;
                3'd4:    data_nx_s = data_r | wd_s;
                default: data_nx_s = data_r;
            endcase
        end else begin
            data_nx_s = data_r;
        end
        case (state_r)
            IDLE: begin
                if (pulse_wr_s) begin
                    mask_nx_s  = wd_s;
                    cnt_nx_s   = pw_eff_s;
                    state_nx_s = ACTIVE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACTIVE: begin
                if (pulse_wr_s) begin
                    mask_nx_s = mask_r | wd_s;
                    cnt_nx_s  = pw_eff_s;
                end else if (cnt_r == {{(PW_WIDTH-1){1'b0}}, 1'b1}) begin
                    data_nx_s  = data_nx_s & ~mask_r;
                    mask_nx_s  = {DATA_WIDTH{1'b0}};
                    cnt_nx_s   = {PW_WIDTH{1'b0}};
                    state_nx_s = IDLE;
                end else if (cnt_r != {PW_WIDTH{1'b0}}) begin
                    cnt_nx_s = cnt_r - {{(PW_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    mask_nx_s  = {DATA_WIDTH{1'b0}};
                    state_nx_s = IDLE;
                end
            end
            default: begin
                mask_nx_s  = {DATA_WIDTH{1'b0}};
                cnt_nx_s   = {PW_WIDTH{1'b0}};
                state_nx_s = IDLE;
            end
        endcase
    end

    // Read mux, sampled every clock
    always_comb begin
        rd_nx_s = 32'd0;
        case (bus.address)
            3'd0: rd_nx_s[DATA_WIDTH-1:0] = data_r;
            3'd1: rd_nx_s[PW_WIDTH-1:0]   = pw_r;
            3'd4: begin
                rd_nx_s[DATA_WIDTH-1:0] = mask_r;
                rd_nx_s[31]             = (state_r == ACTIVE);
            end
            3'd5:    rd_nx_s[PW_WIDTH-1:0] = cnt_r;
            default: rd_nx_s = 32'd0;
        endcase
    end

    // Pulse engine state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            pw_r    <= {{(PW_WIDTH-1){1'b0}}, 1'b1};
            cnt_r   <= {PW_WIDTH{1'b0}};
            mask_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_nx_s;
            pw_r    <= pw_nx_s;
            cnt_r   <= cnt_nx_s;
            mask_r  <= mask_nx_s;
        end
    end
`else
    // Data register decode without the pulse engine
    always_comb begin
        data_nx_s = data_r;
        if (wr_s) begin
            case (bus.address)
                3'd0:    data_nx_s = wd_s;
                3'd2:    data_nx_s = data_r | wd_s;
                3'd3:    data_nx_s = data_r & ~wd_s;
                default: data_nx_s = data_r;
            endcase
        end else begin
            data_nx_s = data_r;
        end
    end

    // Read mux, sampled every clock
    always_comb begin
        rd_nx_s = 32'd0;
        case (bus.address)
            3'd0:    rd_nx_s[DATA_WIDTH-1:0] = data_r;
            default: rd_nx_s = 32'd0;
        endcase
    end
`endif

    // Data and read-data registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r     <= RESET_VALUE;
            readdata_r <= 32'd0;
        end else begin
            data_r     <= data_nx_s;
            readdata_r <= rd_nx_s;
        end
    end

endmodule

// File: tb/tb_nios_upc_pio_out_pulse.sv
// Directed bench for nios_upc_pio_out_pulse with RESET_VALUE=8'hA5; covers the
// pulse engine when PIO_OUT_PULSE_EN is defined, the reduced map otherwise.
module tb_nios_upc_pio_out_pulse;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] out_port;
    logic [31:0] rdv;
    int         checks = 0;
    int         errors = 0;

    nios_upc_pio_out_pulse_if bus ();

    nios_upc_pio_out_pulse #(
        .DATA_WIDTH (8),
        .RESET_VALUE(8'hA5),
        .PW_WIDTH   (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; write lands on the next posedge, returns at the following negedge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        @(negedge clk);
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    initial begin
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_out", {24'd0, out_port}, 32'h0000_00A5);
        chk("reset_rd", bus.readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        wr(3'd0, 32'h0000_003C);
        chk("data_wr", {24'd0, out_port}, 32'h3C);
        wr(3'd2, 32'h0000_0001);
        chk("outset", {24'd0, out_port}, 32'h3D);
        wr(3'd3, 32'h0000_000C);
        chk("outclr", {24'd0, out_port}, 32'h31);
        rd(3'd0, rdv);
        chk("rd_data", rdv, 32'h31);
        rd(3'd2, rdv);
        chk("rd_outset", rdv, 32'd0);
        rd(3'd3, rdv);
        chk("rd_outclr", rdv, 32'd0);
        rd(3'd7, rdv);
        chk("rd_unmapped", rdv, 32'd0);
        wr(3'd0, 32'hFFFF_FF00);
        chk("data_upper_ignored", {24'd0, out_port}, 32'h00);

`ifdef PIO_OUT_PULSE_EN
        rd(3'd1, rdv);
        chk("pw_reset", rdv, 32'd1);
        wr(3'd1, 32'd4);
        rd(3'd1, rdv);
        chk("pw_rd", rdv, 32'd4);

        // PW=4: bit 7 high for exactly four clocks
        wr(3'd4, 32'h80);
        chk("p4_c0", {24'd0, out_port}, 32'h80);
        bus.chipselect = 1'b1;
        bus.address    = 3'd4;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("p4_hi", {24'd0, out_port}, 32'h80);
            chk("p4_stat", bus.readdata, 32'h8000_0080);
        end
        @(negedge clk);
        chk("p4_lo", {24'd0, out_port}, 32'h00);
        @(negedge clk);
        chk("p4_stat_idle", bus.readdata, 32'd0);
        bus.chipselect = 1'b0;
        rd(3'd5, rdv);
        chk("cnt_idle", rdv, 32'd0);

        // PW=0 behaves as one cycle
        wr(3'd1, 32'd0);
        rd(3'd1, rdv);
        chk("pw0_rd", rdv, 32'd0);
        wr(3'd4, 32'h02);
        chk("p1_hi", {24'd0, out_port}, 32'h02);
        @(negedge clk);
        chk("p1_lo", {24'd0, out_port}, 32'h00);

        // Retrigger: both bits clear five clocks after second write
        wr(3'd1, 32'd5);
        wr(3'd4, 32'h01);
        @(negedge clk);
        @(negedge clk);
        wr(3'd4, 32'h10);
        chk("rt_c0", {24'd0, out_port}, 32'h11);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk("rt_hi", {24'd0, out_port}, 32'h11);
        end
        @(negedge clk);
        chk("rt_lo", {24'd0, out_port}, 32'h00);

        // OUTSET on the expiry cycle loses to the expiry clear
        wr(3'd1, 32'd3);
        wr(3'd4, 32'h40);
        @(negedge clk);
        @(negedge clk);
        wr(3'd2, 32'h40);
        chk("exp_wins", {24'd0, out_port}, 32'h00);

        // Reset mid-pulse
        wr(3'd1, 32'd10);
        wr(3'd4, 32'h04);
        chk("mid_hi", {24'd0, out_port}, 32'h04);
        @(negedge clk);
        rd(3'd5, rdv);
        chk("cnt_run", rdv, 32'd9);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out", {24'd0, out_port}, 32'hA5);
        chk("mid_rst_rd", bus.readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd5, rdv);
        chk("mid_rst_cnt", rdv, 32'd0);
        rd(3'd4, rdv);
        chk("mid_rst_stat", rdv, 32'd0);
        repeat (12) @(negedge clk);
        chk("mid_rst_hold", {24'd0, out_port}, 32'hA5);
`else
        rd(3'd1, rdv);
        chk("off_rd1", rdv, 32'd0);
        wr(3'd1, 32'd5);
        rd(3'd1, rdv);
        chk("off_pw_ignored", rdv, 32'd0);
        wr(3'd4, 32'hFF);
        chk("off_pulse_ignored", {24'd0, out_port}, 32'h00);
        rd(3'd4, rdv);
        chk("off_rd4", rdv, 32'd0);
        rd(3'd5, rdv);
        chk("off_rd5", rdv, 32'd0);
        wr(3'd0, 32'h0F);
        wr(3'd2, 32'hF0);
        chk("off_outset", {24'd0, out_port}, 32'hFF);
        reset_n = 1'b0;
        #1;
        chk("off_rst_out", {24'd0, out_port}, 32'hA5);
        chk("off_rst_rd", bus.readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("off_rst_hold", {24'd0, out_port}, 32'hA5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
